residual_row_gen: RTL
=====================

// Module: residual_row_gen
// PURPOSE
//  Parametrised successor to the single-sample difference stage of the SATD datapath.
//  Takes LANES original/current pixel pairs per beat (one block row), emits signed residuals org-cur.
//  Tracks row position inside a ROWS-row block (first/last flags) for the downstream Hadamard stage.
//  Valid/ready handshake on both sides; registered output stage.
// PARAMETERS
//  LANES      4  pixels per beat (block width)
//  BIT_DEPTH  8  pixel width, unsigned
//  ROWS       4  rows per block; power of two, >=2
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous, active-high reset
//  enable     in   1                  1 = accept new rows; 0 = stall input side only
//  in_valid   in   1                  row pair present
//  in_ready   out  1                  row accepted when in_valid & in_ready
//  in_org     in   LANES*BIT_DEPTH    original pixels, lane 0 in LSBs
//  in_cur     in   LANES*BIT_DEPTH    current/predicted pixels, lane 0 in LSBs
//  out_valid  out  1                  residual row present
//  out_ready  in   1                  downstream takes row when out_valid & out_ready
//  out_diff   out  LANES*(BIT_DEPTH+1) signed residuals, lane 0 in LSBs
//  out_first  out  1                  row index 0 of block
//  out_last   out  1                  row index ROWS-1 of block
//  out_sad    out  BIT_DEPTH+clog2(LANES*ROWS) block SAD (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: out_valid=0, out_diff=0, out_first=0, out_last=0, out_sad=0, row counter=0.
//  - Arithmetic per lane: diff = {1'b0,org} - {1'b0,cur}, two's complement, width BIT_DEPTH+1;
//    range -(2^BIT_DEPTH-1)..+(2^BIT_DEPTH-1), never overflows, no saturation.
//  - in_ready = enable & (~out_valid | out_ready) (combinational; single pipeline register, no skid).
//  - Accept beat: next edge loads out_diff, out_valid=1, out_first=(row==0), out_last=(row==ROWS-1),
//    row increments mod ROWS. Latency 1 cycle input handshake -> out_valid.
//  - out_valid & ~out_ready: output holds all fields stable; in_ready=0.
//  - out_valid & out_ready & no accept: out_valid falls next edge; data fields may hold.
//  - Simultaneous drain and accept: out regs reload same edge, out_valid stays 1 (full throughput).
//  - enable=0: no acceptance, row counter frozen; pending output still drains normally.
//  - Row counter advances only on accepted beats; wraps ROWS-1 -> 0 without gap.
//  - rst mid-block: partial block discarded, next accepted row is row 0 (out_first=1).
//  - rst has priority over every other event in the same cycle.
// CONFIGURATION
//  Macro RESIDUAL_SAD_EN:
//   defined: accumulator sums |diff| over all lanes of accepted rows; on the beat tagged out_last,
//    out_sad = SAD of whole block including that row; accumulator clears for next block;
//    out_sad holds until the next last-row beat loads; reset clears accumulator and out_sad.
//   undefined: no accumulator logic; out_sad tied to 0 (port kept for stable interface).
// STRUCTURE
//  Shared package satd_pkg: function diff_w(bit_depth)=bit_depth+1, clog2 helper,
//   typedef/constant for row-counter width clog2(ROWS).
//  Sub-module residual_lane: one lane, combinational diff and |diff|; instantiated LANES times via generate.
//  Top holds handshake register, row counter, optional SAD accumulator.
// TESTING
//  1 Single row org={10,200,0,255} cur={20,100,255,0}, out_ready=1 -> next cycle out_diff={-10,100,-255,255},
//    out_first=1, out_last=0.
//  2 Stream 8 rows back-to-back, out_ready=1 -> out_valid continuous, out_first on rows 0,4, out_last on rows 3,7.
//  3 Hold out_ready=0 after 1 row -> in_ready=0, out_diff stable 5 cycles; release -> drains, accepts next beat.
//  4 enable=0 for 3 cycles mid-block with in_valid=1 -> no accepts, row index resumes (row 2 stays row 2).
//  5 rst after 2 rows, then 1 row -> out_first=1; all outputs 0 and out_valid=0 cycle after rst.
//  6 RESIDUAL_SAD_EN: 4 rows each org=all 255, cur=all 0 -> out_sad=4080 with out_last; without macro out_sad=0.

Source files
------------

// File: rtl/satd_pkg.sv
// Shared constants and width helpers for the SATD datapath stages.
package satd_pkg;

    localparam int DEFAULT_ROWS = 4;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // One extra bit holds the full signed range of an unsigned difference.
    function automatic int diff_w(input int bit_depth);
        return bit_depth + 1;
    endfunction

    function automatic int row_cnt_w(input int rows);
        return (clog2(rows) < 1) ? 1 : clog2(rows);
    endfunction

endpackage

// File: rtl/residual_lane.sv
// One pixel lane: signed residual org-cur and its magnitude, purely combinational.
module residual_lane
    import satd_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic [BIT_DEPTH-1:0]                org,
    input  logic [BIT_DEPTH-1:0]                cur,
    output logic signed [diff_w(BIT_DEPTH)-1:0] diff,
    output logic [BIT_DEPTH-1:0]                abs_diff
);

    always_comb begin
        diff     = {1'b0, org} - {1'b0, cur};
        abs_diff = (org >= cur) ? (org - cur) : (cur - org);
    end

endmodule

// File: rtl/residual_row_gen.sv
// Row-parallel residual generator with block row tagging and a registered output stage.
// Optional block SAD accumulator enabled by defining RESIDUAL_SAD_EN.
module residual_row_gen
    import satd_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int BIT_DEPTH = 8,
    parameter int ROWS      = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [LANES*BIT_DEPTH-1:0]                in_org,
    input  logic [LANES*BIT_DEPTH-1:0]                in_cur,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [LANES*diff_w(BIT_DEPTH)-1:0]        out_diff,
    output logic                                      out_first,
    output logic                                      out_last,
    output logic [BIT_DEPTH+clog2(LANES*ROWS)-1:0]    out_sad
);

    localparam int DW = diff_w(BIT_DEPTH);
    localparam int RW = row_cnt_w(ROWS);
    localparam int SW = BIT_DEPTH + clog2(LANES*ROWS);

    logic [RW-1:0]          row;
    logic                   row_is_last;
    logic                   accept;
    logic [LANES*DW-1:0]    lane_diff;
    logic [BIT_DEPTH-1:0]   lane_abs [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        residual_lane #(
            .BIT_DEPTH (BIT_DEPTH)
        ) u_lane (
            .org      (in_org[i*BIT_DEPTH +: BIT_DEPTH]),
            .cur      (in_cur[i*BIT_DEPTH +: BIT_DEPTH]),
            .diff     (lane_diff[i*DW +: DW]),
            .abs_diff (lane_abs[i])
        );
    end

    // Single output register without skid: accept only when the slot is empty or draining.
    assign in_ready    = enable & (~out_valid | out_ready);
    assign accept      = in_valid & in_ready;
    assign row_is_last = (row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_diff  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            row       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_diff  <= lane_diff;
            out_first <= (row == '0);
            out_last  <= row_is_last;
            row       <= row_is_last ? '0 : row + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RESIDUAL_SAD_EN
    logic [SW-1:0] row_sad;
    logic [SW-1:0] sad_acc;
    logic [SW-1:0] sad_reg;

    always_comb begin
        row_sad = '0;
        for (int i = 0; i < LANES; i++) begin
            row_sad = row_sad + SW'(lane_abs[i]);
        end
    end

    // The last row's contribution is folded in directly so the total lands with out_last.
    always_ff @(posedge clk) begin
        if (rst) begin
            sad_acc <= '0;
            sad_reg <= '0;
        end else if (accept) begin
            if (row_is_last) begin
                sad_reg <= sad_acc + row_sad;
                sad_acc <= '0;
            end else begin
                sad_acc <= sad_acc + row_sad;
            end
        end
    end

    assign out_sad = sad_reg;
`else
    logic unused_abs;

    always_comb begin
        unused_abs = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            unused_abs = unused_abs ^ (^lane_abs[i]);
        end
    end

    assign out_sad = '0;
`endif

endmodule
